// File: rtl/sfp_norm_ctrl.sv
// Softmax-normalisation sequencer: buffers a vector, sums it, then streams (x << FRAC) / sum.
// Optional: define SFP_NORM_SKIP_ZERO_EN to bypass the divider for zero elements of a non-zero-sum vector.
module sfp_norm_ctrl #(
  parameter int N_ELEM = 8,
  parameter int DW     = 20,
  parameter int FRAC   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          div_start,
  output logic [DW-1:0] div_a,
  output logic [DW-1:0] div_b,
  input  logic          div_busy,
  input  logic          div_done,
  input  logic          div_valid,
  input  logic [DW-1:0] div_val,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          out_err
);

  localparam int IW = $clog2(N_ELEM);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_ELEM - 1);
  localparam logic [DW-1:0] MAX_VAL  = '1;

  typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_WAIT, S_OUT} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [DW-1:0] sum;
  logic [DW-1:0] elem_mem [N_ELEM];

  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DW] ? MAX_VAL : s[DW-1:0];
  endfunction

  // Shift into a wide word so overflowing high bits saturate rather than vanish.
  function automatic logic [DW-1:0] sat_shift(input logic [DW-1:0] x);
    logic [DW+FRAC-1:0] w;
    w = {{FRAC{1'b0}}, x} << FRAC;
    return (|w[DW+FRAC-1:DW]) ? MAX_VAL : w[DW-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (state == S_LOAD && in_valid)
      elem_mem[idx] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_LOAD;
      idx       <= '0;
      sum       <= '0;
      in_ready  <= 1'b1;
      div_start <= 1'b0;
      div_a     <= '0;
      div_b     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      div_start <= 1'b0;
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            sum <= sat_add(sum, in_data);
            if (idx == LAST_IDX) begin
              idx      <= '0;
              in_ready <= 1'b0;
              state    <= S_ISSUE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_ISSUE: begin
`ifdef SFP_NORM_SKIP_ZERO_EN
          if (elem_mem[idx] == '0 && sum != '0) begin
            out_data  <= '0;
            out_err   <= 1'b0;
            out_last  <= (idx == LAST_IDX);
            out_valid <= 1'b1;
            state     <= S_OUT;
          end else if (!div_busy) begin
            div_a     <= sat_shift(elem_mem[idx]);
            div_b     <= sum;
            div_start <= 1'b1;
            state     <= S_WAIT;
          end
`else
          if (!div_busy) begin
            div_a     <= sat_shift(elem_mem[idx]);
            div_b     <= sum;
            div_start <= 1'b1;
            state     <= S_WAIT;
          end
`endif
        end
        S_WAIT: begin
          if (div_done) begin
            out_data  <= div_valid ? div_val : MAX_VAL;
            out_err   <= ~div_valid;
            out_last  <= (idx == LAST_IDX);
            out_valid <= 1'b1;
            state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              idx      <= '0;
              sum      <= '0;
              in_ready <= 1'b1;
              state    <= S_LOAD;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_ISSUE;
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule
